// File: rtl/fp_normalize_pack.sv
// FP add/sub back end: normalise the raw mantissa sum, round to nearest-even
// and pack an IEEE-754 single-precision word through a two-stage pipeline.
module fp_normalize_pack #(
  parameter int DataSize     = 32,
  parameter int FractionSize = 23,
  parameter int ExponentSize = 8,
  parameter int SumSize      = 28
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic                    InSign,
  input  logic [ExponentSize-1:0] InExponent,
  input  logic [SumSize-1:0]      InSum,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic [DataSize-1:0]     Result,
  output logic                    Overflow,
  output logic                    Underflow,
  output logic                    Zero
);

  localparam int NW = SumSize - 1;
  localparam int EW = ExponentSize + 2;
  localparam int LW = $clog2(NW);
  localparam logic signed [EW-1:0] EMAX  = EW'((1 << ExponentSize) - 1);
  localparam logic signed [EW-1:0] EZERO = '0;

  logic                 a_valid_q;
  logic                 a_sign_q;
  logic signed [EW-1:0] a_exp_q;
  logic [NW-1:0]        a_man_q;

  logic                 b_valid_q;
  logic [DataSize-1:0]  b_res_q;
  logic                 b_ovf_q;
  logic                 b_unf_q;
  logic                 b_zero_q;

  logic b_load;
  assign b_load  = ~b_valid_q | OutReady;
  assign InReady = ~a_valid_q | b_load;

  logic signed [EW-1:0] e_in;
  logic [LW-1:0]        lz;
  logic                 hit;
  logic [NW-1:0]        a_man_d;
  logic signed [EW-1:0] a_exp_d;

  assign e_in = $signed({2'b00, InExponent});

  always_comb begin
    lz  = '0;
    hit = 1'b0;
    for (int i = NW - 1; i >= 0; i--) begin
      if (!hit && InSum[i]) begin
        lz  = LW'(NW - 1 - i);
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    a_man_d = '0;
    a_exp_d = e_in;
    if (InSum[SumSize-1]) begin
      a_man_d = {InSum[SumSize-1:2], InSum[1] | InSum[0]};
      a_exp_d = e_in + EW'(1);
    end else begin
      a_man_d = InSum[NW-1:0] << lz;
      a_exp_d = e_in - EW'(lz);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      a_valid_q <= 1'b0;
      a_sign_q  <= 1'b0;
      a_exp_q   <= '0;
      a_man_q   <= '0;
    end else if (InReady) begin
      a_valid_q <= InValid;
      if (InValid) begin
        a_sign_q <= InSign;
        a_exp_q  <= a_exp_d;
        a_man_q  <= a_man_d;
      end
    end
  end

  logic                    rnd;
  logic                    fcarry;
  logic [FractionSize-1:0] frac_r;
  logic signed [EW-1:0]    e_r;
  logic [DataSize-1:0]     res_d;
  logic                    ovf_d;
  logic                    unf_d;
  logic                    zero_d;
  logic                    is_zero;

  // A normalised non-zero mantissa always has its leading one at the top bit.
  assign is_zero = ~a_man_q[NW-1];
  assign rnd     = a_man_q[2] & (a_man_q[1] | a_man_q[0] | a_man_q[3]);
  assign {fcarry, frac_r} =
    {1'b0, a_man_q[NW-2:3]} + (FractionSize + 1)'(rnd);
  assign e_r = a_exp_q + EW'(fcarry);

  always_comb begin
    res_d  = '0;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    zero_d = 1'b0;
    if (is_zero) begin
      zero_d = 1'b1;
    end else if (e_r <= EZERO) begin
      res_d = {a_sign_q, {(DataSize-1){1'b0}}};
      unf_d = 1'b1;
    end else if (e_r >= EMAX) begin
      res_d = {a_sign_q, {ExponentSize{1'b1}}, {FractionSize{1'b0}}};
      ovf_d = 1'b1;
    end else begin
      res_d = {a_sign_q, e_r[ExponentSize-1:0], frac_r};
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      b_valid_q <= 1'b0;
      b_res_q   <= '0;
      b_ovf_q   <= 1'b0;
      b_unf_q   <= 1'b0;
      b_zero_q  <= 1'b0;
    end else if (b_load) begin
      b_valid_q <= a_valid_q;
      if (a_valid_q) begin
        b_res_q  <= res_d;
        b_ovf_q  <= ovf_d;
        b_unf_q  <= unf_d;
        b_zero_q <= zero_d;
      end
    end
  end

  assign OutValid  = b_valid_q;
  assign Result    = b_res_q;
  assign Overflow  = b_ovf_q;
  assign Underflow = b_unf_q;
  assign Zero      = b_zero_q;

endmodule

// File: doc/fp_normalize_pack.md
Name: fp_normalize_pack

Overview:
- Final stage of the pipelined FP add/sub datapath: the pack side matching the front-end unpack stage.
- Takes the result sign, the pre-normalisation exponent and the raw mantissa sum with guard/round/sticky bits.
- Normalises, rounds to nearest-even and packs an IEEE-754 single-precision word.
- Two-stage registered pipeline with valid/ready handshakes on both sides.

Parameters:
DataSize, 32, packed result width
FractionSize, 23, stored fraction bits
ExponentSize, 8, exponent field width
SumSize, 28, raw sum width: carry + hidden + FractionSize + guard + round + sticky

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
InValid  input  1  input beat valid
InReady  output  1  stage A can accept a beat
InSign  input  1  result sign
InExponent  input  8  biased exponent of the larger operand
InSum  input  28  raw sum: [27] carry, [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky
OutValid  output  1  Result valid
OutReady  input  1  downstream accepts Result
Result  output  32  packed {sign, exponent, fraction}
Overflow  output  1  result saturated to ±Inf
Underflow  output  1  result flushed to signed zero
Zero  output  1  exact zero result

Behaviour:
- Reset (asynchronous, active-high): both stage valids = 0; OutValid = 0; Result = 0; all flags = 0; InReady = 1 once Reset deasserts.
- Stage A (normalise), registered on InValid & InReady. Exponent arithmetic is 10-bit signed.
  - InSum[27] = 1: shift right 1, exponent + 1, new sticky = old bit0 | old bit1.
  - Else: lz = leading zeros of InSum[26:0] (0..26); shift left by lz; exponent - lz.
  - InSum = 0: mark exact zero.
- Stage B (round and pack), registered when stage B is empty or OutReady = 1.
  - Normalised N[26:0]: LSB = N[3], G = N[2], R = N[1], S = N[0].
  - Round up iff G & (R | S | LSB).
  - Rounded mantissa carries out of 24 bits: fraction = 0, exponent + 1.
- Result selection, in priority order:
  - Exact zero: Result = 32'h00000000 (+0 under RNE), Zero = 1.
  - Final exponent <= 0: flush to {sign, 31'b0}, Underflow = 1. No denormals are produced.
  - Final exponent >= 255: {sign, 8'hFF, 23'b0}, Overflow = 1.
  - Otherwise: {sign, exponent[7:0], fraction}. Flags are per-beat, valid with OutValid.
- Handshake:
  - Stage A advances when stage B is empty or OutReady = 1.
  - InReady = ~A_valid | A_advance (combinational).
  - Result and flags are held stable while OutValid & ~OutReady.
  - No beat is dropped or duplicated; order is preserved.
  - Latency is 2 cycles from accept to OutValid with OutReady held high.
  - Throughput is 1 beat per cycle.
- Simultaneous accept and drain in the same cycle: both happen; no bubble is inserted.
- Reset mid-operation: in-flight beats are discarded; outputs return to reset values immediately.

Test Plan:
- Carry normalise: Sign 0, Exp 127, Sum 28'h8000000 → Result 32'h40000000 two cycles after accept; flags 0.
- Round to nearest-even, both directions:
  - Exp 127, Sum 28'h4000004 (tie, LSB 0) → 32'h3F800000.
  - Sum 28'h400000C (tie, LSB 1) → 32'h3F800002.
- Rounding carry-out: Exp 127, Sum 28'h7FFFFFC → 32'h40000000. Cancellation: Exp 127, Sum 28'h0000008 → lz 23 → 32'h34000000.
- Boundaries:
  - Exp 254, Sum 28'h8000000 → 32'h7F800000, Overflow = 1.
  - Sign 1, Exp 5, Sum 28'h0000008 → 32'h80000000, Underflow = 1.
  - Sum 0 → 32'h00000000, Zero = 1.
- Backpressure: OutReady = 0, offer 3 beats back-to-back.
  - Exactly 2 are accepted; InReady falls; Result is held.
  - Raise OutReady: beats emerge in order, one per cycle; the third is then accepted.
- Reset assertion with both stages full: OutValid = 0 and Result = 0 asynchronously; no stale beat appears after Reset deasserts.
